// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// access-size codes and address-offset helpers.
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW,
        ST_WR,
        ST_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte offset actually used for lane selection; low bits that would make
    // a half or word straddle its natural boundary are dropped.
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends load lanes and merges store
// lanes into a full memory word (little-endian).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        byte_lane = rd_word[{offset, 3'b000} +: 8];
        half_lane = rd_word[{offset[1], 4'b0000} +: 16];
        ld_data   = rd_word;
        merged    = rd_word;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
                merged[{offset, 3'b000} +: 8] = wr_data[7:0];
            end
            SZ_HALF: begin
                ld_data = {{16{sign_ext & half_lane[15]}}, half_lane};
                merged[{offset[1], 4'b0000} +: 16] = wr_data[15:0];
            end
            default: merged = wr_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between CPU datapath and single-port word memory; sub-word
// stores use read-modify-write. Define MISALIGN_TRAP_EN to trap misaligned requests.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              mem_write,
    output logic              mem_read
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merged;
    logic              accept;
    logic              sub_word_q;

    assign accept     = req_valid & req_ready;
    assign sub_word_q = (size_q == SZ_BYTE) || (size_q == SZ_HALF);

    mem_lane_align u_align (
        .size     (size_q),
        .sign_ext (signed_q),
        .offset   (align_offset(size_q, addr_q[1:0])),
        .rd_word  (mem_dataout),
        .wr_data  (wdata_q),
        .ld_data  (ld_data),
        .merged   (merged)
    );

    always_comb begin
        next_state = state;
        req_ready  = (state == ST_IDLE);
        mem_read   = ~Reset & ((state == ST_LOAD) || (state == ST_RMW));
        mem_write  = ~Reset & (state == ST_WR);
        mem_addr   = (state != ST_IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_datain = (state == ST_WR) ? (sub_word_q ? merge_q : wdata_q) : '0;
        case (state)
            ST_IDLE: if (accept) begin
                if (!req_we)
                    next_state = ST_LOAD;
                else if (req_size == SZ_BYTE || req_size == SZ_HALF)
                    next_state = ST_RMW;
                else
                    next_state = ST_WR;
`ifdef MISALIGN_TRAP_EN
                if (is_misaligned(req_size, req_addr[1:0]))
                    next_state = ST_ERR;
`endif
            end
            ST_LOAD: next_state = ST_IDLE;
            ST_RMW:  next_state = ST_WR;
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            resp_valid <= 1'b0;
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
            case (state)
                ST_LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_data;
`ifdef MISALIGN_TRAP_EN
                    err_q      <= 1'b0;
`endif
                end
                ST_RMW: merge_q <= merged;
                ST_WR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
                    err_q      <= 1'b0;
`endif
                end
`ifdef MISALIGN_TRAP_EN
                ST_ERR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    err_q      <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random traffic
// against a byte-array reference model; honours MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_datain, mem_dataout;
    logic        mem_write, mem_read;

    logic [31:0] tb_mem [16];
    logic [7:0]  ref_bytes [64];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mem_access_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout),
        .mem_write   (mem_write),
        .mem_read    (mem_read)
    );

    // Environment memory: combinational read, write on posedge.
    assign mem_dataout = tb_mem[mem_addr[5:2]];
    always @(posedge Clock) if (mem_write) tb_mem[mem_addr[5:2]] <= mem_datain;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] size, input int a);
`ifdef MISALIGN_TRAP_EN
        return (a % size_bytes(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int base;
        base = a - (a % 4);
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input int a);
        int n, base;
        logic [31:0] v;
        n = size_bytes(size);
        base = a - (a % n);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input int a, input logic [31:0] wdata);
        int n, base;
        n = size_bytes(size);
        base = a - (a % n);
        for (int i = 0; i < n; i++) ref_bytes[base+i] = wdata[8*i +: 8];
    endtask

    // Entered just after a negedge; returns at the negedge showing resp_valid,
    // so a following call is accepted in that same response cycle.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int a, lat, reads, writes, exp_lat, exp_reads, exp_writes;
        bit err;
        logic [31:0] exp_rdata, exp_datain, seen_datain;
        a = int'(addr[5:0]);
        err = ref_misaligned(size, a);
        exp_rdata = '0; exp_datain = '0; exp_reads = 0; exp_writes = 0; exp_lat = 1;
        if (err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_rdata = ref_load(size, sgn, a);
            exp_reads = 1;
        end else begin
            ref_store(size, a, wdata);
            exp_datain = ref_word(a);
            exp_writes = 1;
            if (size_bytes(size) < 4) begin
                exp_reads = 1;
                exp_lat = 2;
            end
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge Clock);
        lat = -1; reads = 0; writes = 0; seen_datain = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            if (i == 0) req_valid = 1'b0;
            if (resp_valid) begin
                lat = i;
                break;
            end
            if (mem_read && mem_write) check({tag, ".rd_wr_both"}, 32'd1, 32'd0);
            reads += int'(mem_read);
            writes += int'(mem_write);
            if (mem_write) seen_datain = mem_datain;
            if (mem_read || mem_write) check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(resp_err), 32'(err));
        check({tag, ".reads"}, reads, exp_reads);
        check({tag, ".writes"}, writes, exp_writes);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        if (exp_writes != 0) check({tag, ".datain"}, seen_datain, exp_datain);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int w = 0; w < 16; w++) begin
            tb_mem[w] = (w == 0) ? 32'h80FF7F01 : (w == 1) ? 32'h11223344 : $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*w+b] = tb_mem[w][8*b +: 8];
        end
        Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.mem_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_datain", mem_datain, 32'd0);

        do_txn(1'b0, 2'b00, 1'b1, 32'h2, '0, "lb_signed");
        check("lb_signed.value", resp_rdata, 32'hFFFF_FFFF);
        do_txn(1'b0, 2'b00, 1'b0, 32'h3, '0, "lbu");
        check("lbu.value", resp_rdata, 32'h0000_0080);
        do_txn(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, "sw");
        do_txn(1'b0, 2'b10, 1'b0, 32'h8, '0, "lw");
        check("lw.value", resp_rdata, 32'hDEADBEEF);
        do_txn(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000ABCD, "sh");
        check("sh.word1", tb_mem[1], 32'hABCD3344);
        do_txn(1'b0, 2'b10, 1'b0, 32'h5, '0, "lw_mis");
        do_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, "b2b_sw");
        do_txn(1'b0, 2'b01, 1'b1, 32'h22, '0, "b2b_lh");
        check("b2b_lh.value", resp_rdata, 32'hFFFF_CAFE);

        // Reset during RMW of a byte store; a request held across reset must be ignored.
        @(negedge Clock);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h5A;
        @(posedge Clock);
        @(negedge Clock);
        check("rstmid.in_rmw", 32'(mem_read), 32'd1);
        Reset = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
        check("rstmid.no_write_rst", 32'(mem_write), 32'd0);
        @(negedge Clock);
        check("rstmid.no_write", 32'(mem_write), 32'd0);
        check("rstmid.no_resp", 32'(resp_valid), 32'd0);
        check("rstmid.ready", 32'(req_ready), 32'd1);
        Reset = 1'b0; req_valid = 1'b0;
        @(negedge Clock);
        check("rstmid.not_accepted", {30'd0, mem_write, mem_read}, 32'd0);
        check("rstmid.resp_idle", 32'(resp_valid), 32'd0);
        check("rstmid.mem_word4", tb_mem[4], ref_word(16));

        for (int k = 0; k < 60; k++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom, "rand");
        end

        @(negedge Clock);
        for (int w = 0; w < 16; w++) check("final.mem", tb_mem[w], ref_word(4*w));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
